// File: rtl/debug_pkg.sv
// Shared debug-path definitions: register file geometry defaults and the dump reader state encoding.
package debug_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_FETCH = 3'd2,
    S_SEND  = 3'd3,
    S_FIN   = 3'd4
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Halts the CPU, walks register indices FIRST..LAST through the debug read port and streams
// (index, value) beats to the debug console. The FSM state is visible as state_q.
module regfile_dump_reader
  import debug_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIRST  = 0,
  parameter int LAST   = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // Stream handshake: a beat transfers on a rising edge where out_valid and out_ready are both
  // high; while out_valid is high out_idx/out_data/out_last stay stable. abort withdraws the
  // pending beat in the same cycle so it can never complete.

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              handshake;

  assign out_valid = (state_q == S_SEND) && !abort;
  assign handshake = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HALT;
          idx_d   = FIRST_IDX;
        end
      end
      S_HALT: begin
        if (abort) state_d = S_FIN;
        else if (halt_ack) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_FIN;
        end else begin
          out_idx_d  = idx_q;
          out_data_d = rd_data;
          out_last_d = (idx_q == LAST_IDX);
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_FIN;
        end else if (handshake) begin
          // Terminal test is on the index itself, so the counter never needs to wrap.
          if (out_last_q) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= FIRST_IDX;
      out_idx_q  <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  // Decoded from the registered state so a reset drops the halt request asynchronously.
  assign halt_req = (state_q == S_HALT) || (state_q == S_FETCH) || (state_q == S_SEND);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign rd_addr  = idx_q;
  assign out_idx  = out_idx_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;

endmodule
